// File: rtl/mux.sv
// Two-way data select with a registered copy, select-change pulse and saturating switch counter.
// out is combinational (REGISTERED=0) or one cycle late (REGISTERED=1); there is no backpressure.
module mux #(
   parameter int WIDTH      = 1,
   parameter int REGISTERED = 0,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] da,
   input  logic [WIDTH-1:0] db,
   input  logic             s,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic             sw_pulse,
   output logic [CNT_W-1:0] sw_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] sel_dat;
   logic             sw_evt;

   // Only a definite 1 picks db; 0, X and Z all fall through to da.
   always_comb begin
      sel_dat = da;
      if (s) sel_dat = db;
   end

   assign sw_evt = (s != sel_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q    <= '0;
         sel_q    <= 1'b0;
         sw_pulse <= 1'b0;
         sw_count <= '0;
      end else begin
         out_q    <= sel_dat;
         sel_q    <= s;
         sw_pulse <= sw_evt;
         if (sw_evt && (sw_count != CNT_MAX)) sw_count <= sw_count + 1'b1;
      end
   end

   generate
      if (REGISTERED != 0) begin : g_reg
         assign out = out_q;
      end else begin : g_comb
         assign out = sel_dat;
      end
   endgenerate

endmodule

// File: tb/tb_mux.sv
// Bench for mux: combinational, registered, narrow-counter and single-bit instances share stimulus.
module tb_mux;

   logic       clk;
   logic       rst;
   logic [7:0] da, db;
   logic       s;

   logic [7:0] o0, q0, o1, q1, o2, q2;
   logic [7:0] c0, c1, c3;
   logic [1:0] c2;
   logic       sl0, sl1, sl2, sl3, p0, p1, p2, p3;
   logic [0:0] o3, q3, da1, db1;

   assign da1 = da[0:0];
   assign db1 = db[0:0];

   mux #(.WIDTH(8), .REGISTERED(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .da(da), .db(db), .s(s),
      .out(o0), .out_q(q0), .sel_q(sl0), .sw_pulse(p0), .sw_count(c0));
   mux #(.WIDTH(8), .REGISTERED(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .da(da), .db(db), .s(s),
      .out(o1), .out_q(q1), .sel_q(sl1), .sw_pulse(p1), .sw_count(c1));
   mux #(.WIDTH(8), .REGISTERED(0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .da(da), .db(db), .s(s),
      .out(o2), .out_q(q2), .sel_q(sl2), .sw_pulse(p2), .sw_count(c2));
   mux #(.WIDTH(1), .REGISTERED(0), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .da(da1), .db(db1), .s(s),
      .out(o3), .out_q(q3), .sel_q(sl3), .sw_pulse(p3), .sw_count(c3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int ncmp  = 0;
   int nfail = 0;

   // Reference: the history of select values seen at edges since reset (seeded with the reset 0).
   bit         hist[$];
   logic [7:0] m_outq;

   function automatic int ntrans();
      int n = 0;
      for (int i = 1; i < hist.size(); i++)
         if (hist[i] != hist[i-1]) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      hist.push_back(1'b0);
      m_outq = 8'h00;
   endtask

   task automatic check_all();
      int  n;
      bit  pulse;
      logic [7:0] sel;
      n     = ntrans();
      pulse = (hist.size() >= 2) && (hist[hist.size()-1] != hist[hist.size()-2]);
      sel   = s ? db : da;
      chk("u0_out",   o0, sel);
      chk("u0_outq",  q0, m_outq);
      chk("u0_selq",  sl0, hist[hist.size()-1]);
      chk("u0_pulse", p0, pulse);
      chk("u0_cnt",   c0, (n > 255) ? 255 : n);
      chk("u1_out",   o1, m_outq);
      chk("u1_outq",  q1, m_outq);
      chk("u1_cnt",   c1, (n > 255) ? 255 : n);
      chk("u2_outq",  q2, m_outq);
      chk("u2_pulse", p2, pulse);
      chk("u2_cnt",   c2, (n > 3) ? 3 : n);
      chk("u3_out",   o3, sel[0]);
      chk("u3_outq",  q3, m_outq[0]);
      chk("u3_pulse", p3, pulse);
      chk("u3_cnt",   c3, (n > 255) ? 255 : n);
   endtask

   // One clock edge: inputs are stable, so the model samples them at the edge too.
   task automatic step();
      @(posedge clk);
      hist.push_back(s);
      m_outq = s ? db : da;
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed between edges; called right after step().
   task automatic rst_pulse();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_u1_out", o1, 8'h00);
      #1 rst = 1'b0;
   endtask

   initial begin
      int         pulse_tbl[5];
      int         cnt33_tbl[5];
      int         cnt34_tbl[6];
      logic [7:0] c_hold;
      pulse_tbl = '{0, 1, 0, 1, 1};
      cnt33_tbl = '{0, 1, 1, 2, 3};
      cnt34_tbl = '{1, 2, 3, 3, 3, 3};

      rst = 1'b1; da = 8'h00; db = 8'h00; s = 1'b0;
      model_reset();
      #2;
      check_all();

      // Combinational path keeps following inputs while reset is held.
      db = 8'h5A; da = 8'h11; s = 1'b1;
      #1;
      chk("rst_comb_u0", o0, 8'h5A);
      chk("rst_reg_u1",  o1, 8'h00);
      chk("rst_cnt_u0",  c0, 8'h00);
      s = 1'b0;
      #1;
      chk("rst_comb_da", o0, 8'h11);
      #4 rst = 1'b0;   // released at t=8, between edges

      // Single-bit comb select with no clock edge in between.
      step();
      da = 8'h00; db = 8'h01; s = 1'b0;
      #1 chk("w1_s0", o3, 1'b0);
      #1 s = 1'b1; #0 chk("w1_s1", o3, 1'b1);
      #1 s = 1'b0; #0 chk("w1_s0b", o3, 1'b0);
      #1 s = 1'b1; #0 chk("w1_s1b", o3, 1'b1);
      s = 1'b0; da = 8'h00; db = 8'h00;
      step();

      // Registered output holds its old value until the edge.
      da = 8'h3C; db = 8'hA5; s = 1'b0;
      #1 chk("reg_hold0", o1, 8'h00);
      s = 1'b1;
      #1 chk("reg_hold1", o1, 8'h00);
      step();
      chk("reg_after", o1, 8'hA5);

      // Select sequence 0,1,1,0,1 straight after reset.
      s = 1'b0;
      rst_pulse();
      for (int i = 0; i < 5; i++) begin
         s = (i == 1 || i == 2 || i == 4);
         step();
         chk("seq_pulse", p0, pulse_tbl[i]);
         chk("seq_cnt",   c0, cnt33_tbl[i]);
      end

      // Narrow counter saturates at 3 under continuous toggling.
      s = 1'b0;
      rst_pulse();
      for (int i = 0; i < 6; i++) begin
         s = ~s;
         step();
         chk("sat_cnt2", c2, cnt34_tbl[i]);
         chk("sat_pulse", p2, 1'b1);
      end

      // Data-only activity never counts as a switch.
      step();
      c_hold = c0;
      for (int i = 0; i < 20; i++) begin
         da = 8'($urandom);
         db = 8'($urandom);
         step();
         chk("hold_pulse", p0, 1'b0);
         chk("hold_cnt",   c0, c_hold);
      end

      // Random traffic with occasional mid-cycle resets.
      for (int i = 0; i < 300; i++) begin
         da = 8'($urandom);
         db = 8'($urandom);
         s  = ($urandom_range(3) == 0) ? ~s : s;
         if ($urandom_range(60) == 0) begin
            step();
            rst_pulse();
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
